// File: rtl/inst_rom_loader.sv
// Instruction ROM for the core fetch port with a byte-serial program-load port.
// Bytes are packed big-endian into words written from word 0 upward; fetch returns NOP while loading.
module inst_rom_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [31:0]       addr,
  output logic [31:0]       inst,
  output logic              fetch_err,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_words,
  output logic              ld_ovf
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_mem [0:DEPTH-1];
  logic [ADDR_W:0]   r_word_ptr;
  logic [1:0]        r_byte_cnt;
  logic [31:0]       r_shift;
  logic              r_ovf;

  logic              w_beat;
  logic              w_flush;
  logic              w_full;
  logic              w_wr;
  logic [31:0]       w_word;
  logic              w_aligned;
  logic              w_in_range;
  logic              w_hit;

  // Byte k of a word lands at bits [31-8k -: 8]; ~cnt equals 3-cnt for a 2-bit count.
  assign w_beat  = ld_valid & (r_state == S_LOAD);
  assign w_word  = r_shift | ({24'd0, ld_byte} << {~r_byte_cnt, 3'b000});
  assign w_flush = w_beat & ((r_byte_cnt == 2'd3) | ld_last);
  assign w_full  = r_word_ptr[ADDR_W];
  assign w_wr    = w_flush & ~w_full & rst;

  assign w_aligned  = (addr[1:0] == 2'b00);
  assign w_in_range = (addr[31:ADDR_W+2] == {(30-ADDR_W){1'b0}});
  assign w_hit      = ce & rst & (r_state == S_IDLE) & w_aligned & w_in_range;

  // Next-state and status outputs decoded from the state register.
  always_comb begin
    w_state_nxt = r_state;
    ld_ready    = 1'b0;
    ld_busy     = 1'b1;
    ld_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        ld_busy = 1'b0;
        if (ld_start) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        if (w_beat & ld_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_DONE: begin
        ld_done     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        ld_busy     = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Word assembly, write pointer and overflow tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_word_ptr <= '0;
      r_byte_cnt <= 2'd0;
      r_shift    <= 32'd0;
      r_ovf      <= 1'b0;
    end else if ((r_state == S_IDLE) && ld_start) begin
      r_word_ptr <= '0;
      r_byte_cnt <= 2'd0;
      r_shift    <= 32'd0;
      r_ovf      <= 1'b0;
    end else if (w_beat) begin
      r_byte_cnt <= ld_last ? 2'd0 : (r_byte_cnt + 2'd1);
      r_shift    <= w_flush ? 32'd0 : w_word;
      if (w_flush) begin
        if (w_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_word_ptr <= r_word_ptr + PTR_ONE;
        end
      end
    end
  end

  // Memory is deliberately left uncleared by reset so a loaded program survives it.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_word_ptr[ADDR_W-1:0]] <= w_word;
    end
  end

  assign inst      = w_hit ? r_mem[addr[ADDR_W+1:2]] : 32'd0;
  assign fetch_err = ce & rst & (~w_aligned | ~w_in_range);
  assign ld_words  = r_word_ptr;
  assign ld_ovf    = r_ovf;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: two instances (ADDR_W=10 and ADDR_W=2) share one stimulus stream
// and are checked every cycle against a queue-based reference model.
module tb_inst_rom_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic [31:0] addr = 32'd0;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = 8'd0;
  logic        ld_last = 1'b0;

  logic [31:0] inst0, inst1;
  logic        ferr0, ferr1, rdy0, rdy1, busy0, busy1, done0, done1, ovf0, ovf1;
  logic [10:0] words0;
  logic [2:0]  words1;

  int vectors = 0;
  int miscompares = 0;

  int          D [2] = '{1024, 4};
  int          m_st = 0;            // 0 idle, 1 loading, 2 done
  int          m_words [2] = '{0, 0};
  bit          m_ovf [2] = '{1'b0, 1'b0};
  logic [7:0]  m_cur [$];
  logic [31:0] m_mem [int];
  logic [7:0]  stim [$];

  always #5 clk = ~clk;

  inst_rom_loader #(.ADDR_W(10)) dut0 (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst0), .fetch_err(ferr0),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
    .ld_ready(rdy0), .ld_busy(busy0), .ld_done(done0), .ld_words(words0), .ld_ovf(ovf0)
  );

  inst_rom_loader #(.ADDR_W(2)) dut1 (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst1), .fetch_err(ferr1),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
    .ld_ready(rdy1), .ld_busy(busy1), .ld_done(done1), .ld_words(words1), .ld_ovf(ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: bytes collect in a queue; every 4 bytes (or the last byte) form one word.
  task automatic model_edge();
    logic [31:0] w;
    if (!rst) begin
      m_st = 0;
      m_words = '{0, 0};
      m_ovf = '{1'b0, 1'b0};
      m_cur.delete();
    end else if (m_st == 0) begin
      if (ld_start) begin
        m_st = 1;
        m_words = '{0, 0};
        m_ovf = '{1'b0, 1'b0};
        m_cur.delete();
      end
    end else if (m_st == 1) begin
      if (ld_valid) begin
        m_cur.push_back(ld_byte);
        if (m_cur.size() == 4 || ld_last) begin
          w = 32'd0;
          for (int k = 0; k < m_cur.size(); k++) w[31-8*k -: 8] = m_cur[k];
          for (int d = 0; d < 2; d++) begin
            if (m_words[d] < D[d]) begin
              m_mem[d*100000 + m_words[d]] = w;
              m_words[d]++;
            end else begin
              m_ovf[d] = 1'b1;
            end
          end
          m_cur.delete();
        end
        if (ld_last) m_st = 2;
      end
    end else begin
      m_st = 0;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic [31:0] o_inst;
      logic [31:0] o_words;
      logic        o_err, o_rdy, o_busy, o_done, o_ovf;
      bit          inr, hit, e_err;
      int          key;
      if (d == 0) begin
        o_inst = inst0; o_words = {21'd0, words0}; o_err = ferr0;
        o_rdy = rdy0; o_busy = busy0; o_done = done0; o_ovf = ovf0;
      end else begin
        o_inst = inst1; o_words = {29'd0, words1}; o_err = ferr1;
        o_rdy = rdy1; o_busy = busy1; o_done = done1; o_ovf = ovf1;
      end
      inr   = (int'(addr >> 2) < D[d]);
      e_err = ce && rst && ((addr[1:0] != 2'b00) || !inr);
      hit   = ce && rst && (m_st == 0) && (addr[1:0] == 2'b00) && inr;
      key   = d*100000 + int'(addr >> 2);
      if (!hit) chk($sformatf("inst%0d nop a=%h", d, addr), o_inst, 32'd0);
      else if (m_mem.exists(key)) chk($sformatf("inst%0d a=%h", d, addr), o_inst, m_mem[key]);
      chk($sformatf("fetch_err%0d a=%h", d, addr), {31'd0, o_err}, {31'd0, e_err});
      chk($sformatf("ld_ready%0d", d), {31'd0, o_rdy}, {31'd0, m_st == 1});
      chk($sformatf("ld_busy%0d", d), {31'd0, o_busy}, {31'd0, m_st != 0});
      chk($sformatf("ld_done%0d", d), {31'd0, o_done}, {31'd0, m_st == 2});
      chk($sformatf("ld_words%0d", d), o_words, 32'(m_words[d]));
      chk($sformatf("ld_ovf%0d", d), {31'd0, o_ovf}, {31'd0, m_ovf[d]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic fetch(input logic [31:0] a);
    ce = 1'b1;
    addr = a;
    #1;
    check_all();
  endtask

  // Sends stim with random idle gaps; if no_last, the final byte is not flagged and load stays open.
  task automatic run_load(input bit no_last);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < stim.size(); i++) begin
      while ($urandom_range(3) == 0) begin
        ld_valid = 1'b0;
        ld_byte  = 8'($urandom);
        ld_last  = 1'($urandom);
        ld_start = 1'($urandom);
        tick();
      end
      ld_valid = 1'b1;
      ld_byte  = stim[i];
      ld_last  = !no_last && (i == stim.size() - 1);
      ld_start = 1'($urandom);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_start = 1'b0;
    if (!no_last) begin
      tick();
      tick();
    end
  endtask

  initial begin
    tick();
    fetch(32'd0);
    tick();
    rst = 1'b1;
    tick();

    // T1
    stim = '{8'h34, 8'h01, 8'h00, 8'h05, 8'h34, 8'h02, 8'h00, 8'h07};
    run_load(1'b0);
    chk("T1 words", {21'd0, words0}, 32'd2);
    fetch(32'd0);
    chk("T1 word0", inst0, 32'h34010005);
    fetch(32'd4);
    chk("T1 word1", inst0, 32'h34020007);

    // T2
    stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_load(1'b0);
    chk("T2 words", {21'd0, words0}, 32'd2);
    fetch(32'd4);
    chk("T2 padded", inst0, 32'hEE000000);

    // T3
    fetch(32'd2);
    chk("T3 misaligned err", {31'd0, ferr0}, 32'd1);
    fetch(32'd4096);
    chk("T3 range err", {31'd0, ferr0}, 32'd1);
    fetch(32'd16);
    fetch(32'hFFFF_FFFC);

    // T4: fetch held at word 0 across a load
    fetch(32'd0);
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_load(1'b0);
    fetch(32'd0);
    chk("T4 after load", inst0, 32'h11223344);

    // T5: small instance overflows, big instance keeps all five words
    stim.delete();
    for (int i = 0; i < 20; i++) stim.push_back(8'(8'h10 + i));
    run_load(1'b0);
    chk("T5 words small", {29'd0, words1}, 32'd4);
    chk("T5 ovf small", {31'd0, ovf1}, 32'd1);
    chk("T5 ovf big", {31'd0, ovf0}, 32'd0);
    fetch(32'd0);
    chk("T5 no wrap", inst1, 32'h10111213);

    // T6: reset after 2 bytes of the fourth word
    stim.delete();
    for (int i = 0; i < 14; i++) stim.push_back(8'(8'hA0 + i));
    run_load(1'b1);
    rst = 1'b0;
    tick();
    chk("T6 busy", {31'd0, busy0}, 32'd0);
    chk("T6 words", {21'd0, words0}, 32'd0);
    chk("T6 ready", {31'd0, rdy0}, 32'd0);
    rst = 1'b1;
    tick();
    fetch(32'd8);
    chk("T6 word2", inst0, 32'hA8A9AAAB);
    fetch(32'd12);
    fetch(32'd0);

    // Randomized loads and fetches
    for (int n = 0; n < 12; n++) begin
      stim.delete();
      for (int i = 0; i < int'($urandom_range(1, 40)); i++) stim.push_back(8'($urandom));
      ce = 1'($urandom);
      run_load(1'b0);
      for (int f = 0; f < 8; f++) begin
        case ($urandom_range(4))
          0: fetch({26'd0, 4'($urandom), 2'b00});
          1: fetch({26'd0, 6'($urandom)});
          2: fetch($urandom);
          3: fetch(32'd4096);
          default: fetch(32'd16);
        endcase
        if ($urandom_range(1) == 0) tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
